// File: rtl/moving_avg_filter.sv
// ============================================================================
// Module : moving_avg_filter
// Boxcar moving-average smoother with runtime power-of-two window, running sum
// over a circular sample buffer. Optional macro MAVG_ROUND_EN selects
// round-half-up instead of truncation toward -inf.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module moving_avg_filter #(
  parameter int BIT_WIDTH     = 16,
  parameter int MAX_LOG2_TAPS = 3,
  parameter int SEL_WIDTH     = 3
) (
  input  logic                        clk,
  input  logic                        sclr,
  input  logic [SEL_WIDTH-1:0]        filt_sel,
  input  logic                        in_valid,
  input  logic signed [BIT_WIDTH-1:0] d,
  output logic                        out_valid,
  output logic signed [BIT_WIDTH-1:0] q,
  output logic                        primed
);

  localparam int DEPTH = 1 << MAX_LOG2_TAPS;
  localparam int PW    = MAX_LOG2_TAPS;
  localparam int FW    = MAX_LOG2_TAPS + 1;
  localparam int KW    = $clog2(MAX_LOG2_TAPS + 1);
  localparam int SW    = BIT_WIDTH + MAX_LOG2_TAPS;
`ifdef MAVG_ROUND_EN
  localparam int AW    = SW + 1;
`else
  localparam int AW    = SW;
`endif

  logic signed [BIT_WIDTH-1:0] mem_q [DEPTH];

  logic [PW-1:0]               wr_ptr_q, wr_ptr_d;
  logic [FW-1:0]               fill_q, fill_d;
  logic signed [SW-1:0]        sum_q, sum_d;
  logic [KW-1:0]               k_q, k_d;
  logic signed [BIT_WIDTH-1:0] q_q, q_d;
  logic                        primed_q, primed_d;
  logic                        out_valid_q;

  logic [KW-1:0]               k_eff;
  logic [FW-1:0]               n_win;
  logic [PW-1:0]               rd_ptr;
  logic                        restart;
  logic signed [SW-1:0]        base_sum;
  logic [FW-1:0]               base_fill;
  logic signed [BIT_WIDTH-1:0] old_term;
  logic signed [AW-1:0]        acc;

  // Out-of-range selects clamp to the deepest window.
  always_comb begin
    k_eff = KW'(MAX_LOG2_TAPS);
    if (32'(filt_sel) < 32'(MAX_LOG2_TAPS)) begin
      k_eff = KW'(filt_sel);
    end
  end

  assign restart = (k_eff != k_q);
  assign n_win   = FW'(1) << k_eff;
  // A full-depth window truncates N to 0 here, so the slot being overwritten is the oldest.
  assign rd_ptr  = wr_ptr_q - PW'(n_win);

  always_comb begin
    base_sum  = restart ? '0 : sum_q;
    base_fill = restart ? '0 : fill_q;
    old_term  = '0;
    if (!restart && (fill_q >= n_win)) begin
      old_term = mem_q[rd_ptr];
    end

    sum_d    = base_sum;
    fill_d   = base_fill;
    primed_d = restart ? 1'b0 : primed_q;
    wr_ptr_d = wr_ptr_q;
    k_d      = k_eff;
    q_d      = q_q;
    acc      = '0;

    if (in_valid) begin
      sum_d    = base_sum + SW'(d) - SW'(old_term);
      fill_d   = (base_fill >= n_win) ? base_fill : base_fill + FW'(1);
      primed_d = (fill_d == n_win);
      wr_ptr_d = wr_ptr_q + PW'(1);
`ifdef MAVG_ROUND_EN
      // Half an LSB of the quotient; n_win >> 1 is zero for a single-tap window.
      acc = {sum_d[SW-1], sum_d};
      acc = acc + AW'(n_win >> 1);
`else
      acc = sum_d;
`endif
      q_d = BIT_WIDTH'(acc >>> k_eff);
    end
  end

  always_ff @(posedge clk) begin
    if (sclr) begin
      wr_ptr_q    <= '0;
      fill_q      <= '0;
      sum_q       <= '0;
      k_q         <= k_eff;
      q_q         <= '0;
      primed_q    <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      fill_q      <= fill_d;
      sum_q       <= sum_d;
      k_q         <= k_d;
      q_q         <= q_d;
      primed_q    <= primed_d;
      out_valid_q <= in_valid;
    end
  end

  // Sample storage is never cleared; the fill count hides stale entries.
  always_ff @(posedge clk) begin
    if (in_valid && !sclr) begin
      mem_q[wr_ptr_q] <= d;
    end
  end

  assign q         = q_q;
  assign out_valid = out_valid_q;
  assign primed    = primed_q;

endmodule

`default_nettype wire

// File: tb/tb_moving_avg_filter.sv
// ============================================================================
// Module : tb_moving_avg_filter
// Directed vector table plus randomized stimulus against a queue-based model.
// Rev    : 1.0
// ============================================================================
`default_nettype none

module tb_moving_avg_filter;

`ifdef MAVG_ROUND_EN
  localparam bit RND = 1'b1;
`else
  localparam bit RND = 1'b0;
`endif
  localparam int MAXK = 3;

  logic               clk = 1'b0;
  logic               sclr;
  logic [2:0]         filt_sel;
  logic               in_valid;
  logic signed [15:0] d;
  logic               out_valid;
  logic signed [15:0] q;
  logic               primed;

  moving_avg_filter #(
    .BIT_WIDTH    (16),
    .MAX_LOG2_TAPS(MAXK),
    .SEL_WIDTH    (3)
  ) dut (
    .clk      (clk),
    .sclr     (sclr),
    .filt_sel (filt_sel),
    .in_valid (in_valid),
    .d        (d),
    .out_valid(out_valid),
    .q        (q),
    .primed   (primed)
  );

  always #5 clk = ~clk;

  int n_vec = 0;
  int n_bad = 0;

  // Reference model: the samples seen since the last reset / window change.
  int hist[$];
  int m_k  = 0;
  int m_q  = 0;
  bit m_ov = 1'b0;
  bit m_pr = 1'b0;

  typedef struct {
    bit rst;
    int sel;
    bit vld;
    int din;
    bit chk;
    bit ov;
    int qx;
    bit pr;
  } vec_t;

  vec_t tbl[$];

  function automatic int keff(input int sel);
    return (sel > MAXK) ? MAXK : sel;
  endfunction

  function automatic longint floor_div(input longint num, input longint den);
    if (num >= 0) return num / den;
    return -((-num + den - 1) / den);
  endfunction

  function automatic int model_avg();
    longint s = 0;
    int     n = 1 << m_k;
    int     sz = hist.size();
    for (int i = 0; i < n; i++) begin
      if (i < sz) s += hist[sz - 1 - i];
    end
    if (RND) s += n / 2;
    return int'(floor_div(s, n));
  endfunction

  task automatic model_update(input bit rst, input int sel, input bit vld, input int din);
    if (rst) begin
      hist.delete();
      m_q  = 0;
      m_ov = 1'b0;
      m_pr = 1'b0;
      m_k  = keff(sel);
    end else begin
      if (keff(sel) != m_k) begin
        hist.delete();
        m_k = keff(sel);
      end
      m_ov = vld;
      if (vld) begin
        hist.push_back(din);
        if (hist.size() > (1 << MAXK)) void'(hist.pop_front());
        m_q = model_avg();
      end
      m_pr = (hist.size() >= (1 << m_k));
    end
  endtask

  task automatic check(input string name, input int act, input int exp);
    n_vec++;
    if (act != exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit rst, input int sel, input bit vld, input int din);
    sclr     = rst;
    filt_sel = 3'(sel);
    in_valid = vld;
    d        = 16'(din);
    @(posedge clk);
    model_update(rst, sel, vld, din);
    #1;
    check("model_out_valid", int'(out_valid), int'(m_ov));
    check("model_q", int'(q), m_q);
    check("model_primed", int'(primed), int'(m_pr));
  endtask

  initial begin
    int sel;
    bit r;
    bit v;
    int din;

    sclr = 1'b1; filt_sel = '0; in_valid = 1'b0; d = '0;

    // reset, single tap
    tbl.push_back('{1, 0, 0,   0, 1, 0,   0, 0});
    tbl.push_back('{0, 0, 1, 100, 1, 1, 100, 1});
    // 4-tap ramp, slide, hold
    tbl.push_back('{0, 2, 1,   4, 1, 1,   1, 0});
    tbl.push_back('{0, 2, 1,   8, 1, 1,   3, 0});
    tbl.push_back('{0, 2, 1,  12, 1, 1,   6, 0});
    tbl.push_back('{0, 2, 1,  16, 1, 1,  10, 1});
    tbl.push_back('{0, 2, 1,  20, 1, 1,  14, 1});
    tbl.push_back('{0, 2, 0,   0, 1, 0,  14, 1});
    // negative rounding
    tbl.push_back('{0, 1, 1,  -3, 1, 1, RND ? -1 : -2, 0});
    tbl.push_back('{0, 1, 1,  -4, 1, 1, RND ? -3 : -4, 1});
    // full-scale, 8 taps
    for (int i = 0; i < 8; i++) tbl.push_back('{0, 3, 1, 32767, i == 7, 1, 32767, 1});
    for (int i = 0; i < 8; i++) tbl.push_back('{0, 3, 1, -32768, i == 7, 1, -32768, 1});
    // select change on a primed window
    for (int i = 0; i < 4; i++) tbl.push_back('{0, 2, 1, 50, i == 3, 1, 50, 1});
    tbl.push_back('{0, 1, 1, 50, 1, 1, 25, 0});
    tbl.push_back('{0, 1, 1, 50, 1, 1, 50, 1});
    // reset mid-fill, then clamped select
    tbl.push_back('{0, 3, 1,  10, 0, 1,  0, 0});
    tbl.push_back('{0, 3, 1,  20, 0, 1,  0, 0});
    tbl.push_back('{1, 3, 1, 999, 1, 0,  0, 0});
    for (int i = 0; i < 8; i++)
      tbl.push_back('{0, 5, 1, 80, (i == 0) || (i >= 6), 1, 10 * (i + 1), i == 7});
    tbl.push_back('{0, 5, 1, 0, 1, 1, 70, 1});

    foreach (tbl[i]) begin
      step(tbl[i].rst, tbl[i].sel, tbl[i].vld, tbl[i].din);
      if (tbl[i].chk) begin
        check($sformatf("tbl[%0d].out_valid", i), int'(out_valid), int'(tbl[i].ov));
        check($sformatf("tbl[%0d].q", i), int'(q), tbl[i].qx);
        check($sformatf("tbl[%0d].primed", i), int'(primed), int'(tbl[i].pr));
      end
    end

    // idle cycle with select change: window restarts, q holds
    step(1'b0, 2, 1'b0, 0);
    check("restart_idle_primed", int'(primed), 0);

    sel = 2;
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(15) == 0) sel = int'($urandom_range(7));
      r = ($urandom_range(99) == 0);
      v = ($urandom_range(3) != 0);
      case ($urandom_range(5))
        0:       din = 32767;
        1:       din = -32768;
        default: din = int'($signed(16'($urandom)));
      endcase
      step(r, sel, v, din);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule

`default_nettype wire
